// File: rtl/bad_point_lut_builder.sv
// Passive monitor on the aligned pixel/k stream: records coordinates of
// pixels with k <= threshold into the DPC manual bad-point LUT, one frame per arm.
module bad_point_lut_builder #(
    parameter int K_WIDTH       = 16,
    parameter int CNT_WIDTH     = 10,
    parameter int BAD_POINT_NUM = 128,
    parameter int BAD_POINT_BIT = 7
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     k_axis_tvalid,
    input  logic [K_WIDTH-1:0]       k_axis_tdata,
    input  logic [CNT_WIDTH-1:0]     frame_height,
    input  logic [K_WIDTH-1:0]       k_thresh,
    input  logic                     start,
    input  logic                     abort,
    output logic                     wen_lut,
    output logic [BAD_POINT_BIT-1:0] waddr_lut,
    output logic [31:0]              wdata_lut,
    output logic [BAD_POINT_BIT:0]   bad_point_num,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [BAD_POINT_BIT:0] NUM_MAX = (BAD_POINT_BIT+1)'(BAD_POINT_NUM);

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     x_q, x_d;
    logic [CNT_WIDTH-1:0]     y_q, y_d;
    logic [K_WIDTH-1:0]       thresh_q, thresh_d;
    logic                     wen_q, wen_d;
    logic [BAD_POINT_BIT-1:0] waddr_q, waddr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [BAD_POINT_BIT:0]   num_q, num_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic                     ferr_q, ferr_d;

    logic                     beat;
    logic                     is_bad;
    logic                     last_line;
    logic                     full;
    logic                     eval;
    logic [CNT_WIDTH-1:0]     bx, by;
    logic [31:0]              coord;

    assign beat      = s_axis_tvalid & s_axis_tready & k_axis_tvalid;
    assign is_bad    = (k_axis_tdata <= thresh_q);
    assign full      = (num_q >= NUM_MAX);

    // SOF forces the beat to (0,0) regardless of where the counters drifted
    assign bx        = s_axis_tuser ? '0 : x_q;
    assign by        = s_axis_tuser ? '0 : y_q;
    assign last_line = (by == frame_height - CNT_WIDTH'(1));

    always_comb begin
        coord                   = '0;
        coord[CNT_WIDTH-1:0]    = bx;
        coord[16 +: CNT_WIDTH]  = by;
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (beat) begin
            if (s_axis_tlast) begin
                x_d = '0;
                y_d = by + CNT_WIDTH'(1);
            end else begin
                x_d = bx + CNT_WIDTH'(1);
                y_d = by;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        thresh_d = thresh_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        num_d    = num_q;
        ovf_d    = ovf_q;
        ferr_d   = ferr_q;
        eval     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    thresh_d = k_thresh;
                    num_d    = '0;
                    ovf_d    = 1'b0;
                    ferr_d   = 1'b0;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (beat && s_axis_tuser) begin
                    eval    = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (beat) begin
                    if (s_axis_tuser) begin
                        ferr_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        eval = 1'b1;
                        if (s_axis_tlast && last_line) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (eval && is_bad) begin
            if (!full) begin
                wen_d   = 1'b1;
                waddr_d = num_q[BAD_POINT_BIT-1:0];
                wdata_d = coord;
                num_d   = num_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // done and busy follow the next state so they line up with the last write
    assign done_d = (state_d == S_DONE);
    assign busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            thresh_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            num_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            thresh_q <= thresh_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            num_q    <= num_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    assign wen_lut       = wen_q;
    assign waddr_lut     = waddr_q;
    assign wdata_lut     = wdata_q;
    assign bad_point_num = num_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign frame_err     = ferr_q;

endmodule

// File: doc/bad_point_lut_builder.md
# bad_point_lut_builder

Scans the aligned pixel/k-value stream for one armed frame, finds pixels whose gain coefficient k is at or below a threshold, and writes their coordinates into the DPC manual bad-point LUT. It drives the LUT write port (`wen_lut`/`waddr_lut`/`wdata_lut`) and `bad_point_num`. It is the writer side of the LUT the DPC reads. It sits in parallel with the DPC input as a passive monitor and never stalls the stream.

## Interface
- `K_WIDTH`, 16, k-value width
- `CNT_WIDTH`, 10, coordinate counter width (≤16)
- `BAD_POINT_NUM`, 128, LUT depth (max entries written)
- `BAD_POINT_BIT`, 7, LUT address width, log2(`BAD_POINT_NUM`)

Ports:
- `aclk`  in  1  sole clock; the LUT write port is synchronous to it, so the DPC's `S_AXI_ACLK` is tied to `aclk`
- `reset`  in  1  asynchronous, active-high
- `s_axis_tvalid`, `s_axis_tready`  in  1  pixel-stream handshake (observed only)
- `s_axis_tuser`  in  1  SOF
- `s_axis_tlast`  in  1  EOL
- `k_axis_tvalid`  in  1  k-stream valid
- `k_axis_tdata`  in  K_WIDTH  k value aligned to the pixel
- `frame_height`  in  CNT_WIDTH  lines per frame; static while busy
- `k_thresh`  in  K_WIDTH  pixel is bad if k ≤ `k_thresh` (0 means k==0 only); sampled at arm
- `start`  in  1  one-cycle arm pulse
- `abort`  in  1  one-cycle cancel pulse
- `wen_lut`  out  1  LUT write strobe
- `waddr_lut`  out  BAD_POINT_BIT  LUT address
- `wdata_lut`  out  32  coordinates: [CNT_WIDTH-1:0] = x, [16+CNT_WIDTH-1:16] = y, all other bits 0
- `bad_point_num`  out  BAD_POINT_BIT+1  entries written in the current/last capture
- `busy`  out  1  state is ARMED or CAPTURE
- `done`  out  1  one-cycle pulse when a capture ends
- `overflow`  out  1  sticky: more bad pixels than `BAD_POINT_NUM`
- `frame_err`  out  1  sticky: SOF arrived before the last line completed

## Operation
- A beat is a cycle with `s_axis_tvalid & s_axis_tready & k_axis_tvalid`. No other cycle advances anything.
- Beat coordinates:
  - A beat with `tuser` is (0,0).
  - Otherwise the beat takes the current (x,y) counters.
  - After a beat: if `tlast`, x←0 and y←y+1; else x←x+1.
  - The counters run in every state.
- States:
  - IDLE: `start` samples `k_thresh`, clears `bad_point_num`, `overflow` and `frame_err`, then goes to ARMED. `start` in any other state is ignored.
  - ARMED: the first beat with `tuser` is evaluated as a capture beat, then the state goes to CAPTURE.
  - CAPTURE: every beat is evaluated. A `tlast` beat with y == `frame_height`-1 is evaluated, then the state goes to DONE. A `tuser` beat ends the capture without being evaluated, sets `frame_err`, and goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- `abort` in ARMED or CAPTURE returns to IDLE the next cycle. It produces no `done`. `bad_point_num` keeps the entries already written. `abort` takes priority over `start` and over a same-cycle end of frame.
- Evaluating a beat, when k ≤ threshold:
  - If `bad_point_num` < `BAD_POINT_NUM`: write one entry at address = `bad_point_num`[BAD_POINT_BIT-1:0], then increment `bad_point_num`.
  - Otherwise set `overflow` and do not write.
- `bad_point_num` saturates at `BAD_POINT_NUM` and never wraps.

## Timing
- Reset values: every output is 0, the state is IDLE, and the counters are 0.
- Reset mid-capture drops the capture. Partial LUT contents are left as written.
- Write latency is 1 cycle. For a bad beat in cycle n, `wen_lut`, `waddr_lut` and `wdata_lut` are valid in cycle n+1 for exactly one cycle. `bad_point_num` increments in that same cycle n+1.
- Back-to-back bad beats produce back-to-back writes, so throughput is one write per cycle.
- `waddr_lut` and `wdata_lut` are registered and hold their last value while `wen_lut` is 0.
- `done` is asserted 1 cycle after the cycle of the last evaluated beat. A write for that beat coincides with `done`.
- `busy` falls in the same cycle `done` rises.
- `busy` rises 1 cycle after `start`.

## Test plan
Bench setup: `frame_height`=4, 8-pixel lines, `BAD_POINT_NUM`=4.

- Arm, one frame, k=0 at (3,1) and (7,3), all other k=100 → two writes: addr0 = 0x0001_0003, addr1 = 0x0003_0007. `bad_point_num`=2, `done` 1 cycle after the final beat, `overflow`=0.
- `k_thresh`=5, k=5 at (0,0) and k=6 at (1,0) → only (0,0) is written, at addr0, 1 cycle after the SOF beat.
- Six bad pixels in one frame → four writes (addr0–3), `bad_point_num`=4, `overflow`=1, no fifth `wen_lut`.
- Random `tvalid` gaps and `k_axis_tvalid` drops on bad pixels → coordinates are unchanged versus the gap-free run, and no write occurs on a non-beat cycle.
- SOF after line 2 while in CAPTURE → `frame_err`=1, `done` pulse, and the SOF beat is not written even with k=0.
- Arm, then `abort` after 2 writes; then `start` + a full frame → no `done` for the aborted run; the second run restarts at addr0 and `bad_point_num` reflects only the second frame. Asserting `reset` mid-frame → all outputs 0 on the next edge.
